rv_pipe_ctrl: RTL and testbench
===============================

Name: rv_pipe_ctrl

Overview:
- Pipelined successor to the single-cycle RV32I control decoder.
- Sits at the ID stage of the 5-stage core (IF/ID/EX/MEM/WB).
- Decodes the ID instruction and carries the control bundle through its own ID/EX, EX/MEM and MEM/WB registers.
- Also detects load-use hazards, flushes on taken branches/jumps, generates EX operand-forwarding selects, and flags illegal encodings.
- Parametrised for the optional M extension and for RV32E register count.

Parameters:
ENABLE_M, 0, 1 = decode RV32M (funct7=0000001 in R-type); 0 = those encodings are illegal.
REG_ADDR_W, 5, 5 = RV32I (32 regs); 4 = RV32E (any rd/rs1/rs2 field >= 16 is illegal).

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_id  in  32  instruction in ID
id_valid  in  1  instr_id valid; 0 = decode as bubble
br_taken_ex  in  1  branch/jump in EX resolved taken
stall_if_id  out  1  hold PC and IF/ID register
flush_if_id  out  1  squash IF/ID contents
illegal_id  out  1  combinational: instr_id is illegal (only when id_valid)
ex_aluop  out  5  {M-op, funct7[5], funct3}; LUI = 01111
ex_immsrc  out  3  immediate format
ex_brop  out  5  branch op; 00000 = none
ex_alu_a_src, ex_alu_b_src  out  1 each  ALU operand muxes
fwd_a, fwd_b  out  2  00 regfile, 01 from EX/MEM, 10 from MEM/WB
mem_dmwr  out  1  data-memory write
mem_dmctrl  out  3  load/store size (funct3)
wb_ruwr  out  1  regfile write enable
wb_datasrc  out  2  00 ALU, 01 memory, 10 PC+4
wb_rd  out  5  destination register

Behaviour:
- Decode table (combinational on instr_id; RV32I opcodes R, I, L, S, B, LUI, AUIPC, JAL, JALR):
  - ImmSrc: I=000, S=001, U=010, B=101, J=110.
  - OP-IMM: ALUOp takes funct7[5] only for funct3=101 (shifts); SRAI works and ADDI never becomes SUB.
  - B: BrOp={01,funct3}. JAL/JALR: BrOp=10000, RUDataWrSrc=10.
- Illegal (unknown opcode, bad funct7, bad reg field per parameters, M-op when ENABLE_M=0):
  - Decoded as bubble and illegal_id=1.
  - A bubble has RuWr=0, DMWr=0, BrOp=00000; all other fields 0.
- Pipeline:
  - Control reaches ex_* 1 cycle after the instruction is accepted in ID, mem_* after 2, wb_* after 3.
  - EX/MEM and MEM/WB advance every cycle, never stall.
- Load-use hazard (combinational):
  - Condition: EX holds a load (RuWr=1, datasrc=01) with rd != 0, and rd equals the ID rs1 (if used) or rs2 (if used).
  - Used fields: rs1 unused for LUI/AUIPC/JAL; rs2 used only for R/S/B.
  - Response: stall_if_id=1 and a bubble enters ID/EX next cycle. Exactly 1 cycle of stall per hazard.
- Taken branch:
  - br_taken_ex=1 gives flush_if_id=1 the same cycle, and ID/EX loads a bubble.
  - Flush has priority over stall: stall_if_id=0 when br_taken_ex=1.
- Forwarding (for the instruction in EX, per operand):
  - 01 if EX/MEM RuWr=1, rd!=0, rd==rs, and EX/MEM is not a load.
  - Else 10 if MEM/WB RuWr=1, rd!=0, rd==rs.
  - Else 00.
  - x0 is never forwarded.
- Reset: asynchronous. All three pipeline registers reset to bubble; all outputs 0 (fwd 00, stall/flush 0, wb_rd 0). Takes effect immediately mid-operation. First valid decode is on the first edge after rst_n rises.

Test Plan:
- Reset, then id_valid=1, instr 0x00A00093 (addi x1,x0,10) -> next cycle ex_aluop=00000, ex_alu_b_src=1; 3 cycles later wb_ruwr=1, wb_rd=1, wb_datasrc=00.
- lw x5,0(x2)=0x00012283, then add x6,x5,x1=0x00128333 -> stall_if_id=1 for exactly 1 cycle, bubble in EX; add reaches EX with fwd_a=10.
- add x3,x1,x2 followed by sub x4,x3,x3 (0x40318233) -> fwd_a=fwd_b=01; with one nop between them -> 10; rd=x0 producer -> 00.
- beq in EX with br_taken_ex=1 while a load-use hazard is present -> flush_if_id=1, stall_if_id=0; next ex_* is a bubble (ex_brop=0, later wb_ruwr=0).
- 0xFFFFFFFF -> illegal_id=1, propagates as bubble. mul x3,x1,x2=0x022081B3: ENABLE_M=0 -> illegal; ENABLE_M=1 -> ex_aluop=10000. REG_ADDR_W=4 with add x17,x1,x2 -> illegal.
- rst_n dropped mid-stream with valid ops in all stages -> all outputs 0 asynchronously (before the next clock edge); after release, no stale wb_ruwr.

Source files
------------

// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: RV32I(M/E) ID-stage decoder carrying control through ID/EX, EX/MEM, MEM/WB with hazard, flush and forwarding logic
//   in : clk, rst_n (async, active low), instr_id, id_valid, br_taken_ex
//   out: stall_if_id, flush_if_id, illegal_id
//        ex_aluop, ex_immsrc, ex_brop, ex_alu_a_src, ex_alu_b_src, fwd_a, fwd_b
//        mem_dmwr, mem_dmctrl, wb_ruwr, wb_datasrc, wb_rd
module rv_pipe_ctrl #(
  parameter bit ENABLE_M   = 1'b0,
  parameter int REG_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_id,
  input  logic        id_valid,
  input  logic        br_taken_ex,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        illegal_id,
  output logic [4:0]  ex_aluop,
  output logic [2:0]  ex_immsrc,
  output logic [4:0]  ex_brop,
  output logic        ex_alu_a_src,
  output logic        ex_alu_b_src,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_dmwr,
  output logic [2:0]  mem_dmctrl,
  output logic        wb_ruwr,
  output logic [1:0]  wb_datasrc,
  output logic [4:0]  wb_rd
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;
  // Source register fields are stored zeroed when the instruction does not
  // read them, so x0 compare logic alone keeps unused fields from matching.
  typedef struct packed {
    logic [4:0] aluop;
    logic [2:0] immsrc;
    logic [4:0] brop;
    logic       a_src;
    logic       b_src;
    logic       dmwr;
    logic [2:0] dmctrl;
    logic       ruwr;
    logic [1:0] datasrc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } id_ex_t;
  typedef struct packed {
    logic       dmwr;
    logic [2:0] dmctrl;
    logic       ruwr;
    logic [1:0] datasrc;
    logic [4:0] rd;
  } ex_mem_t;
  typedef struct packed {
    logic       ruwr;
    logic [1:0] datasrc;
    logic [4:0] rd;
  } mem_wb_t;
  id_ex_t  dec, id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic       legal, rd_used, rs1_used, rs2_used, bad_reg, load_use;
  assign opcode = instr_id[6:0];
  assign rd_f   = instr_id[11:7];
  assign f3     = instr_id[14:12];
  assign rs1_f  = instr_id[19:15];
  assign rs2_f  = instr_id[24:20];
  assign f7     = instr_id[31:25];
  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    rd_used  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        legal     = f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) ||
                    (ENABLE_M && f7 == F7_MUL);
        {rd_used, rs1_used, rs2_used} = 3'b111;
        dec.aluop = {f7 == F7_MUL, f7[5], f3};
        dec.ruwr  = 1'b1;
      end
      OP_I: begin
        // Only shifts carry funct7; ADDI with imm[10] set must stay an add.
        legal     = f3 == 3'b001 ? f7 == F7_ZERO : f3 == 3'b101 ? (f7 == F7_ZERO || f7 == F7_ALT) : 1'b1;
        {rd_used, rs1_used} = 2'b11;
        dec.aluop = {1'b0, f3 == 3'b101 && f7[5], f3};
        dec.b_src = 1'b1;
        dec.ruwr  = 1'b1;
      end
      OP_L: begin
        legal       = f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111;
        {rd_used, rs1_used} = 2'b11;
        dec.b_src   = 1'b1;
        dec.dmctrl  = f3;
        dec.ruwr    = 1'b1;
        dec.datasrc = 2'b01;
      end
      OP_S: begin
        legal      = f3 <= 3'b010;
        {rs1_used, rs2_used} = 2'b11;
        dec.immsrc = 3'b001;
        dec.b_src  = 1'b1;
        dec.dmwr   = 1'b1;
        dec.dmctrl = f3;
      end
      OP_B: begin
        legal      = f3 != 3'b010 && f3 != 3'b011;
        {rs1_used, rs2_used} = 2'b11;
        dec.immsrc = 3'b101;
        dec.brop   = {2'b01, f3};
      end
      OP_LUI: begin
        legal      = 1'b1;
        rd_used    = 1'b1;
        dec.aluop  = 5'b01111;
        dec.immsrc = 3'b010;
        dec.b_src  = 1'b1;
        dec.ruwr   = 1'b1;
      end
      OP_AUIPC: begin
        legal      = 1'b1;
        rd_used    = 1'b1;
        dec.immsrc = 3'b010;
        dec.a_src  = 1'b1;
        dec.b_src  = 1'b1;
        dec.ruwr   = 1'b1;
      end
      OP_JAL: begin
        legal       = 1'b1;
        rd_used     = 1'b1;
        dec.immsrc  = 3'b110;
        dec.brop    = 5'b10000;
        dec.a_src   = 1'b1;
        dec.b_src   = 1'b1;
        dec.ruwr    = 1'b1;
        dec.datasrc = 2'b10;
      end
      OP_JALR: begin
        legal       = f3 == 3'b000;
        {rd_used, rs1_used} = 2'b11;
        dec.brop    = 5'b10000;
        dec.b_src   = 1'b1;
        dec.ruwr    = 1'b1;
        dec.datasrc = 2'b10;
      end
      default: legal = 1'b0;
    endcase
    dec.rd  = rd_used  ? rd_f  : 5'd0;
    dec.rs1 = rs1_used ? rs1_f : 5'd0;
    dec.rs2 = rs2_used ? rs2_f : 5'd0;
  end
  // RV32E: only x0..x15 exist, so bit 4 of any referenced register field is illegal.
  assign bad_reg = REG_ADDR_W < 5 &&
                   ((rd_used && rd_f[4]) || (rs1_used && rs1_f[4]) || (rs2_used && rs2_f[4]));
  always_comb begin
    load_use    = id_valid && legal && !bad_reg && id_ex_q.ruwr && id_ex_q.datasrc == 2'b01 &&
                  id_ex_q.rd != 5'd0 && (id_ex_q.rd == dec.rs1 || id_ex_q.rd == dec.rs2);
    stall_if_id = load_use && !br_taken_ex;
    flush_if_id = br_taken_ex && rst_n;
    illegal_id  = id_valid && (!legal || bad_reg) && rst_n;
    id_ex_d     = (id_valid && legal && !bad_reg && !load_use && !br_taken_ex) ? dec : '0;
    ex_mem_d    = '{dmwr: id_ex_q.dmwr, dmctrl: id_ex_q.dmctrl, ruwr: id_ex_q.ruwr,
                    datasrc: id_ex_q.datasrc, rd: id_ex_q.rd};
    mem_wb_d    = '{ruwr: ex_mem_q.ruwr, datasrc: ex_mem_q.datasrc, rd: ex_mem_q.rd};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  // A load in EX/MEM has no data yet, so it never feeds the EX operand directly.
  always_comb begin
    fwd_a = (ex_mem_q.ruwr && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1 && ex_mem_q.datasrc != 2'b01) ? 2'b01 :
            (mem_wb_q.ruwr && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1) ? 2'b10 : 2'b00;
    fwd_b = (ex_mem_q.ruwr && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2 && ex_mem_q.datasrc != 2'b01) ? 2'b01 :
            (mem_wb_q.ruwr && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2) ? 2'b10 : 2'b00;
  end
  assign ex_aluop     = id_ex_q.aluop;
  assign ex_immsrc    = id_ex_q.immsrc;
  assign ex_brop      = id_ex_q.brop;
  assign ex_alu_a_src = id_ex_q.a_src;
  assign ex_alu_b_src = id_ex_q.b_src;
  assign mem_dmwr     = ex_mem_q.dmwr;
  assign mem_dmctrl   = ex_mem_q.dmctrl;
  assign wb_ruwr      = mem_wb_q.ruwr;
  assign wb_datasrc   = mem_wb_q.datasrc;
  assign wb_rd        = mem_wb_q.rd;
endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// tb_rv_pipe_ctrl: scoreboard bench for rv_pipe_ctrl (base, M-enabled and RV32E instances)
module tb_rv_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, br_taken_ex = 1'b0;
  logic [31:0] instr_id = 32'h0;
  logic stall_if_id, flush_if_id, illegal_id, ex_alu_a_src, ex_alu_b_src, mem_dmwr, wb_ruwr;
  logic [4:0] ex_aluop, ex_brop, wb_rd;
  logic [2:0] ex_immsrc, mem_dmctrl;
  logic [1:0] fwd_a, fwd_b, wb_datasrc;
  logic m_stall, m_flush, m_illegal, m_a_src, m_b_src, m_dmwr, m_ruwr;
  logic [4:0] m_aluop, m_brop, m_rd;
  logic [2:0] m_immsrc, m_dmctrl;
  logic [1:0] m_fwd_a, m_fwd_b, m_datasrc;
  logic e_stall, e_flush, e_illegal, e_a_src, e_b_src, e_dmwr, e_ruwr;
  logic [4:0] e_aluop, e_brop, e_rd;
  logic [2:0] e_immsrc, e_dmctrl;
  logic [1:0] e_fwd_a, e_fwd_b, e_datasrc;
  typedef struct packed {
    logic       ruwr;
    logic [1:0] src;
    logic [4:0] rd;
  } wb_t;
  localparam wb_t BUB = '0;
  wb_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [33:0] all_out;
  assign all_out = {stall_if_id, flush_if_id, illegal_id, ex_aluop, ex_immsrc, ex_brop, ex_alu_a_src,
                    ex_alu_b_src, fwd_a, fwd_b, mem_dmwr, mem_dmctrl, wb_ruwr, wb_datasrc, wb_rd};
  localparam logic [31:0] ADDI1  = 32'h00A00093, LW5   = 32'h00012283, ADD6 = 32'h00128333;
  localparam logic [31:0] ADD3   = 32'h002081B3, SUB4  = 32'h40318233, NOP  = 32'h00000013;
  localparam logic [31:0] ADD0   = 32'h00208033, SUB40 = 32'h40000233, BEQ  = 32'h00208463;
  localparam logic [31:0] JAL1   = 32'h000000EF, LUI7  = 32'h123453B7, SW5  = 32'h00512223;
  localparam logic [31:0] SRAI1  = 32'h4030D093, ADDIN = 32'h40000093, MUL3 = 32'h022081B3;
  localparam logic [31:0] ADD17  = 32'h002088B3, ILL   = 32'hFFFFFFFF;
  always #5 clk = ~clk;
  rv_pipe_ctrl #(.ENABLE_M(1'b0), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .id_valid(id_valid), .br_taken_ex(br_taken_ex),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .illegal_id(illegal_id),
    .ex_aluop(ex_aluop), .ex_immsrc(ex_immsrc), .ex_brop(ex_brop), .ex_alu_a_src(ex_alu_a_src),
    .ex_alu_b_src(ex_alu_b_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_dmwr(mem_dmwr),
    .mem_dmctrl(mem_dmctrl), .wb_ruwr(wb_ruwr), .wb_datasrc(wb_datasrc), .wb_rd(wb_rd));
  rv_pipe_ctrl #(.ENABLE_M(1'b1), .REG_ADDR_W(5)) dut_m (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .id_valid(id_valid), .br_taken_ex(br_taken_ex),
    .stall_if_id(m_stall), .flush_if_id(m_flush), .illegal_id(m_illegal),
    .ex_aluop(m_aluop), .ex_immsrc(m_immsrc), .ex_brop(m_brop), .ex_alu_a_src(m_a_src),
    .ex_alu_b_src(m_b_src), .fwd_a(m_fwd_a), .fwd_b(m_fwd_b), .mem_dmwr(m_dmwr),
    .mem_dmctrl(m_dmctrl), .wb_ruwr(m_ruwr), .wb_datasrc(m_datasrc), .wb_rd(m_rd));
  rv_pipe_ctrl #(.ENABLE_M(1'b0), .REG_ADDR_W(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .id_valid(id_valid), .br_taken_ex(br_taken_ex),
    .stall_if_id(e_stall), .flush_if_id(e_flush), .illegal_id(e_illegal),
    .ex_aluop(e_aluop), .ex_immsrc(e_immsrc), .ex_brop(e_brop), .ex_alu_a_src(e_a_src),
    .ex_alu_b_src(e_b_src), .fwd_a(e_fwd_a), .fwd_b(e_fwd_b), .mem_dmwr(e_dmwr),
    .mem_dmctrl(e_dmctrl), .wb_ruwr(e_ruwr), .wb_datasrc(e_datasrc), .wb_rd(e_rd));
  task automatic drive(input logic [31:0] ins, input logic v, input logic br);
    instr_id = ins;
    id_valid = v;
    br_taken_ex = br;
    #1;
  endtask
  // Push what should enter ID/EX this edge; the entry pushed two edges earlier is now in MEM/WB.
  task automatic cyc(input wb_t e);
    wb_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      x = sb.pop_front();
      n_chk++;
      if ({wb_ruwr, wb_datasrc, wb_rd} !== x) begin
        n_fail++;
        $display("FAIL wb_bundle: got ruwr=%b src=%b rd=%0d, want ruwr=%b src=%b rd=%0d",
                 wb_ruwr, wb_datasrc, wb_rd, x.ruwr, x.src, x.rd);
      end
    end
  endtask
  task automatic test_reset();
    drive(ADDI1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (all_out !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_addi();
    drive(ADDI1, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd1});
    n_chk++;
    if ({ex_aluop, ex_alu_b_src, ex_immsrc} !== {5'b00000, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL addi_ex: got aluop=%b bsrc=%b imm=%b want 00000 1 000", ex_aluop, ex_alu_b_src, ex_immsrc);
    end
    drive(32'h0, 1'b0, 1'b0);
    repeat (3) cyc(BUB);
  endtask
  task automatic test_load_use();
    drive(LW5, 1'b1, 1'b0);
    cyc('{1'b1, 2'b01, 5'd5});
    drive(ADD6, 1'b1, 1'b0);
    n_chk++;
    if (stall_if_id !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall_on: got %b want 1", stall_if_id);
    end
    cyc(BUB);
    n_chk++;
    if ({ex_aluop, ex_alu_b_src, ex_immsrc, mem_dmctrl} !== {5'b0, 1'b0, 3'b0, 3'b010}) begin
      n_fail++;
      $display("FAIL lu_bubble: got aluop=%b bsrc=%b imm=%b memctrl=%b want 0 0 0 010",
               ex_aluop, ex_alu_b_src, ex_immsrc, mem_dmctrl);
    end
    n_chk++;
    if (stall_if_id !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_stall_once: got %b want 0", stall_if_id);
    end
    cyc('{1'b1, 2'b00, 5'd6});
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL lu_fwd: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
    end
    drive(32'h0, 1'b0, 1'b0);
    repeat (2) cyc(BUB);
  endtask
  task automatic test_forward();
    drive(ADD3, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd3});
    drive(SUB4, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd4});
    n_chk++;
    if ({fwd_a, fwd_b, ex_aluop} !== {2'b01, 2'b01, 5'b01000}) begin
      n_fail++;
      $display("FAIL fwd_exmem: got a=%b b=%b aluop=%b want 01 01 01000", fwd_a, fwd_b, ex_aluop);
    end
    drive(ADD3, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd3});
    drive(NOP, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd0});
    drive(SUB4, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd4});
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      n_fail++;
      $display("FAIL fwd_memwb: got a=%b b=%b want 10 10", fwd_a, fwd_b);
    end
    drive(ADD0, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd0});
    drive(SUB40, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd4});
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL fwd_x0: got a=%b b=%b want 00 00", fwd_a, fwd_b);
    end
  endtask
  task automatic test_branch_flush();
    drive(LW5, 1'b1, 1'b0);
    cyc('{1'b1, 2'b01, 5'd5});
    drive(ADD6, 1'b1, 1'b1);
    n_chk++;
    if ({flush_if_id, stall_if_id} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_prio: got flush=%b stall=%b want 1 0", flush_if_id, stall_if_id);
    end
    cyc(BUB);
    n_chk++;
    if ({ex_brop, ex_aluop, ex_alu_b_src} !== 11'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: got brop=%b aluop=%b bsrc=%b want 0", ex_brop, ex_aluop, ex_alu_b_src);
    end
    drive(BEQ, 1'b1, 1'b0);
    n_chk++;
    if ({flush_if_id, stall_if_id} !== 2'b00) begin
      n_fail++;
      $display("FAIL beq_ctl: got flush=%b stall=%b want 0 0", flush_if_id, stall_if_id);
    end
    cyc(BUB);
    n_chk++;
    if ({ex_brop, ex_immsrc} !== {5'b01000, 3'b101}) begin
      n_fail++;
      $display("FAIL beq_ex: got brop=%b imm=%b want 01000 101", ex_brop, ex_immsrc);
    end
    drive(JAL1, 1'b1, 1'b0);
    cyc('{1'b1, 2'b10, 5'd1});
    n_chk++;
    if ({ex_brop, ex_immsrc, ex_alu_a_src} !== {5'b10000, 3'b110, 1'b1}) begin
      n_fail++;
      $display("FAIL jal_ex: got brop=%b imm=%b asrc=%b want 10000 110 1", ex_brop, ex_immsrc, ex_alu_a_src);
    end
    drive(LUI7, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd7});
    n_chk++;
    if ({ex_aluop, ex_immsrc} !== {5'b01111, 3'b010}) begin
      n_fail++;
      $display("FAIL lui_ex: got aluop=%b imm=%b want 01111 010", ex_aluop, ex_immsrc);
    end
    drive(SW5, 1'b1, 1'b0);
    cyc(BUB);
    n_chk++;
    if (ex_immsrc !== 3'b001) begin
      n_fail++;
      $display("FAIL sw_imm: got %b want 001", ex_immsrc);
    end
    drive(SRAI1, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd1});
    n_chk++;
    if ({ex_aluop, mem_dmwr, mem_dmctrl} !== {5'b01101, 1'b1, 3'b010}) begin
      n_fail++;
      $display("FAIL srai_sw: got aluop=%b dmwr=%b dmctrl=%b want 01101 1 010", ex_aluop, mem_dmwr, mem_dmctrl);
    end
    drive(ADDIN, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd1});
    n_chk++;
    if (ex_aluop !== 5'b00000) begin
      n_fail++;
      $display("FAIL addi_not_sub: got %b want 00000", ex_aluop);
    end
  endtask
  task automatic test_illegal();
    drive(ILL, 1'b0, 1'b0);
    n_chk++;
    if (illegal_id !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_invalid: got %b want 0", illegal_id);
    end
    drive(ILL, 1'b1, 1'b0);
    n_chk++;
    if (illegal_id !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_ff: got %b want 1", illegal_id);
    end
    cyc(BUB);
    n_chk++;
    if ({ex_aluop, ex_immsrc, ex_brop, ex_alu_a_src, ex_alu_b_src} !== 15'b0) begin
      n_fail++;
      $display("FAIL illegal_bubble: got aluop=%b imm=%b brop=%b want 0", ex_aluop, ex_immsrc, ex_brop);
    end
    drive(MUL3, 1'b1, 1'b0);
    n_chk++;
    if ({illegal_id, m_illegal} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_legal: got base=%b m=%b want 1 0", illegal_id, m_illegal);
    end
    cyc(BUB);
    n_chk++;
    if ({m_aluop, ex_aluop} !== {5'b10000, 5'b00000}) begin
      n_fail++;
      $display("FAIL mul_aluop: got m=%b base=%b want 10000 00000", m_aluop, ex_aluop);
    end
    drive(ADD17, 1'b1, 1'b0);
    n_chk++;
    if ({illegal_id, e_illegal} !== 2'b01) begin
      n_fail++;
      $display("FAIL rv32e_reg: got base=%b e=%b want 0 1", illegal_id, e_illegal);
    end
    cyc('{1'b1, 2'b00, 5'd17});
    drive(32'h0, 1'b0, 1'b0);
    repeat (2) cyc(BUB);
  endtask
  task automatic test_async_reset();
    drive(ADDI1, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd1});
    drive(LW5, 1'b1, 1'b0);
    cyc('{1'b1, 2'b01, 5'd5});
    drive(ADD3, 1'b1, 1'b0);
    cyc('{1'b1, 2'b00, 5'd3});
    drive(ILL, 1'b1, 1'b1);
    n_chk++;
    if ({wb_ruwr, flush_if_id, illegal_id} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset_busy: got wb=%b flush=%b ill=%b want 1 1 1", wb_ruwr, flush_if_id, illegal_id);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (all_out !== 34'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", all_out);
    end
    sb.delete();
    drive(32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(BUB);
    n_chk++;
    if (wb_ruwr !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_wb: got %b want 0", wb_ruwr);
    end
  endtask
  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_forward();
    test_branch_flush();
    test_illegal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
